pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 158 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: holds the PLL in reset, qualifies a filtered lock indication,
// retries on timeout and releases the downstream core reset only while lock holds.
module pll_lock_sequencer #(
    parameter int RST_HOLD    = 16,
    parameter int LOCK_FILTER = 1024,
    parameter int TIMEOUT     = 65536,
    parameter int MAX_RETRY   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_reset,
    output logic       locked_ok,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int FILT_W = $clog2(LOCK_FILTER + 1);
    localparam int TMO_W  = $clog2(TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
    // The entry edge itself is the first timeout tick, so the deciding value is TIMEOUT-2.
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 2);
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RUN    = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync2_q;
    logic              lock_s;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [3:0]        retry_q, retry_d, retry_inc;
    logic [7:0]        loss_q, loss_d;
    logic              pll_rst_q, core_reset_q, locked_ok_q, fail_q;
    logic              pll_rst_d, core_reset_d, locked_ok_d, fail_d;

    assign lock_s    = sync2_q;
    assign retry_inc = retry_q + 4'd1;

    // Next-state and counter logic; counters are cleared whenever their state is left.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        filt_d  = filt_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (relock_req) begin
            state_d = ST_ASSERT;
            retry_d = 4'd0;
            hold_d  = {HOLD_W{1'b0}};
            filt_d  = {FILT_W{1'b0}};
            tmo_d   = {TMO_W{1'b0}};
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_WAIT;
                        hold_d  = {HOLD_W{1'b0}};
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (lock_s && (filt_q == FILT_LAST)) begin
                        state_d = ST_RUN;
                        retry_d = 4'd0;
                        filt_d  = {FILT_W{1'b0}};
                        tmo_d   = {TMO_W{1'b0}};
                    end else if (tmo_q == TMO_LAST) begin
                        retry_d = retry_inc;
                        filt_d  = {FILT_W{1'b0}};
                        tmo_d   = {TMO_W{1'b0}};
                        if (retry_inc == RETRY_MAX) begin
                            state_d = ST_FAIL;
                        end else begin
                            state_d = ST_ASSERT;
                        end
                    end else begin
                        filt_d = lock_s ? (filt_q + 1'b1) : {FILT_W{1'b0}};
                        tmo_d  = tmo_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_ASSERT;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end else begin
                            loss_d = loss_q;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
    end

    assign pll_rst_d    = (state_d == ST_ASSERT) || (state_d == ST_FAIL);
    assign core_reset_d = (state_d != ST_RUN);
    assign locked_ok_d  = (state_d == ST_RUN);
    assign fail_d       = (state_d == ST_FAIL);

    // Lock synchronizer, state, counters and output registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= ST_ASSERT;
            hold_q       <= {HOLD_W{1'b0}};
            filt_q       <= {FILT_W{1'b0}};
            tmo_q        <= {TMO_W{1'b0}};
            retry_q      <= 4'd0;
            loss_q       <= 8'd0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            locked_ok_q  <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            sync1_q      <= pll_locked;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            hold_q       <= hold_d;
            filt_q       <= filt_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_rst_q    <= pll_rst_d;
            core_reset_q <= core_reset_d;
            locked_ok_q  <= locked_ok_d;
            fail_q       <= fail_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign core_reset = core_reset_q;
    assign locked_ok  = locked_ok_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;
    assign loss_cnt   = loss_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: each scenario queues (cycle, signal, value)
// expectations and compares them as the matching cycle is sampled.
module tb_pll_lock_sequencer;
    localparam int RST_HOLD    = 4;
    localparam int LOCK_FILTER = 8;
    localparam int TIMEOUT     = 32;
    localparam int MAX_RETRY   = 3;

    localparam int S_PLL   = 0;
    localparam int S_CORE  = 1;
    localparam int S_LOCK  = 2;
    localparam int S_FAIL  = 3;
    localparam int S_RETRY = 4;
    localparam int S_LOSS  = 5;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       core_reset;
    logic       locked_ok;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    pll_lock_sequencer #(
        .RST_HOLD   (RST_HOLD),
        .LOCK_FILTER(LOCK_FILTER),
        .TIMEOUT    (TIMEOUT),
        .MAX_RETRY  (MAX_RETRY)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .core_reset(core_reset),
        .locked_ok (locked_ok),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] get_sig(int s);
        case (s)
            S_PLL:   return {31'd0, pll_rst};
            S_CORE:  return {31'd0, core_reset};
            S_LOCK:  return {31'd0, locked_ok};
            S_FAIL:  return {31'd0, fail};
            S_RETRY: return {28'd0, retry_cnt};
            S_LOSS:  return {24'd0, loss_cnt};
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic string sig_name(int s);
        case (s)
            S_PLL:   return "pll_rst";
            S_CORE:  return "core_reset";
            S_LOCK:  return "locked_ok";
            S_FAIL:  return "fail";
            S_RETRY: return "retry_cnt";
            S_LOSS:  return "loss_cnt";
            default: return "unknown";
        endcase
    endfunction

    function automatic void push(int c, int s, int v);
        sb.push_back('{c, s, v});
    endfunction

    task automatic tick();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        relock_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        exp_t e;
        pll_locked = 1'b1;
        apply_reset();
        push(0, S_PLL, 1);   push(0, S_CORE, 1);  push(0, S_LOCK, 0);
        push(0, S_FAIL, 0);  push(0, S_RETRY, 0); push(0, S_LOSS, 0);
        push(1, S_PLL, 1);   push(1, S_CORE, 1);  push(3, S_PLL, 1);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                failures++;
                $display("FAIL reset %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
            end
        end
        while (cyc < 4) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                    failures++;
                    $display("FAIL reset %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                end
            end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        pll_locked = 1'b1;
        apply_reset();
        push(4, S_PLL, 1);   push(5, S_PLL, 0);   push(5, S_CORE, 1);
        push(12, S_CORE, 1); push(12, S_LOCK, 0);
        push(13, S_CORE, 0); push(13, S_LOCK, 1); push(13, S_PLL, 0); push(13, S_RETRY, 0);
        while (cyc < 16) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                    failures++;
                    $display("FAIL lock %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                end
            end
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        pll_locked = 1'b0;
        apply_reset();
        for (int c = 1; c <= 112; c++) begin
            push(c, S_CORE, 1);
            if (c == 35)  push(c, S_RETRY, 0);
            if (c == 36)  push(c, S_RETRY, 1);
            if (c == 71)  push(c, S_RETRY, 1);
            if (c == 72)  push(c, S_RETRY, 2);
            if (c == 107) begin push(c, S_FAIL, 0); push(c, S_RETRY, 2); end
            if (c == 108) begin push(c, S_FAIL, 1); push(c, S_RETRY, 3); end
            if (c == 109) push(c, S_PLL, 1);
            if (c == 112) begin push(c, S_FAIL, 1); push(c, S_PLL, 1); push(c, S_LOCK, 0); end
        end
        while (cyc < 112) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                    failures++;
                    $display("FAIL timeout %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                end
            end
        end
    endtask

    // Continues from the FAIL state left by test_timeout.
    task automatic test_fail_relock();
        exp_t e;
        pll_locked = 1'b1;
        push(114, S_FAIL, 1);  push(115, S_FAIL, 0);  push(115, S_RETRY, 0); push(115, S_PLL, 1);
        push(127, S_LOCK, 0);  push(127, S_CORE, 1);  push(128, S_LOCK, 1);  push(128, S_CORE, 0);
        while (cyc < 130) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                    failures++;
                    $display("FAIL relock %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                end
            end
            relock_req = (cyc == 114);
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        pll_locked = 1'b1;
        apply_reset();
        push(13, S_LOCK, 0); push(18, S_LOCK, 0); push(18, S_CORE, 1);
        push(19, S_LOCK, 1); push(19, S_CORE, 0);
        while (cyc < 22) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                    failures++;
                    $display("FAIL glitch %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                end
            end
            pll_locked = (cyc != 8);
        end
    endtask

    task automatic test_loss();
        exp_t e;
        pll_locked = 1'b1;
        apply_reset();
        push(20, S_LOCK, 1); push(22, S_LOCK, 1); push(22, S_LOSS, 0);
        push(23, S_CORE, 1); push(23, S_LOCK, 0); push(23, S_PLL, 1); push(23, S_LOSS, 1); push(23, S_RETRY, 0);
        push(27, S_PLL, 1);  push(28, S_PLL, 0);  push(35, S_LOCK, 0); push(36, S_LOCK, 1); push(36, S_LOSS, 1);
        push(41, S_LOCK, 0); push(41, S_PLL, 1);  push(41, S_LOSS, 1);
        push(53, S_LOCK, 0); push(54, S_LOCK, 1); push(54, S_LOSS, 1);
        while (cyc < 56) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                    failures++;
                    $display("FAIL loss %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                end
            end
            pll_locked = (cyc != 20);
            relock_req = (cyc == 40);
        end
    endtask

    task automatic test_midreset();
        exp_t e;
        pll_locked = 1'b1;
        apply_reset();
        push(8, S_PLL, 0);
        push(9, S_PLL, 1);   push(9, S_CORE, 1);  push(9, S_LOCK, 0);
        push(9, S_FAIL, 0);  push(9, S_RETRY, 0); push(9, S_LOSS, 0);
        push(21, S_LOCK, 0); push(22, S_LOCK, 1); push(28, S_LOSS, 1);
        push(43, S_LOCK, 1); push(43, S_LOSS, 1);
        push(44, S_LOSS, 0); push(44, S_LOCK, 0); push(44, S_PLL, 1); push(44, S_CORE, 1); push(44, S_RETRY, 0);
        while (cyc < 46) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                    failures++;
                    $display("FAIL midreset %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                end
            end
            rst        = (cyc == 8) || (cyc == 43);
            pll_locked = (cyc != 25);
        end
    endtask

    // Each single-cycle lock drop in RUN costs 16 cycles to re-enter RUN.
    task automatic test_saturation();
        exp_t e;
        int   r;
        pll_locked = 1'b1;
        apply_reset();
        push(13, S_LOCK, 1);
        while (cyc < 13) begin
            tick();
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                    failures++;
                    $display("FAIL saturate %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                end
            end
        end
        for (int n = 1; n <= 257; n++) begin
            r = cyc;
            push(r + 3, S_LOSS, (n > 255) ? 255 : n);
            push(r + 16, S_LOCK, 1);
            for (int k = 0; k < 16; k++) begin
                pll_locked = (k != 0);
                tick();
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    checks++;
                    if (e.cyc != cyc || get_sig(e.sig) !== e.val) begin
                        failures++;
                        $display("FAIL saturate %s@%0d: got %0h expected %0h", sig_name(e.sig), e.cyc, get_sig(e.sig), e.val);
                    end
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        test_reset();
        test_lock();
        test_timeout();
        test_fail_relock();
        test_glitch();
        test_loss();
        test_midreset();
        test_saturation();
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: %0d expectations never reached, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
